ahb_gpio_ctrl: RTL and testbench

AHB-Lite single-master controller that shares the AHBGPIO peripheral between two command requesters. Round-robin arbitration picks one requester; the controller sequences the direction-register and data-register AHB transfers and returns one response per command. It tracks the GPIO direction so each requester issues only WRITE_OUT / READ_IN intents. It also times out a hung slave and reports read parity errors.

---
 rtl/gpio_ctrl_pkg.sv | 37 +++
 rtl/rr_arb2.sv | 31 +++
 rtl/ahb_gpio_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ahb_gpio_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared types and constants for the AHB GPIO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_ctrl_pkg;

  // Command intents issued by requesters.
  typedef enum logic [1:0] {
    OP_WRITE_OUT = 2'b00,
    OP_READ_IN   = 2'b01,
    OP_SET_DIR   = 2'b10,
    OP_RSVD      = 2'b11
  } op_e;

  // Controller FSM: optional direction transfer, then the command's own transfer.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIR_A,
    ST_DIR_D,
    ST_XFER_A,
    ST_XFER_D
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Values written to the GPIO direction register.
  localparam logic [15:0] DIR_OUT = 16'h0001;
  localparam logic [15:0] DIR_IN  = 16'h0000;

  // One AHB transfer as presented on the address/data buses.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [15:0] data;
  } xfer_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
// Latency: grant is combinational from req; history updates on the accept edge.
// Backpressure: grant is only consumed when the caller raises accept.
// Ports: clk/rst (sync, active-high), req[1:0], accept, gnt[1:0] one-hot, gnt_id.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_grant;

  always_comb begin
    gnt[0] = req[0] & (~req[1] | last_grant);
    gnt[1] = req[1] & (~req[0] | ~last_grant);
    gnt_id = gnt[1];
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/ahb_gpio_ctrl.sv
// AHB-Lite master sharing the GPIO slave between two command requesters.
// Latency: accept->rsp 3 cycles zero-wait, 5 with a direction insert, +1 per wait state.
// Backpressure: reqN_ready only in IDLE for the arbiter winner; slave stalls via HREADYOUT, aborted after TIMEOUT_CYCLES.
// Ports: HCLK/HRESET (sync, active-high); req0_*/req1_* valid-ready command inputs;
//        rsp_* one-cycle response; H* AHB-Lite master bus; PARITYERR/PARITYSEL parity sideband.
module ahb_gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h5300_0000,
  parameter logic [31:0] DATA_OFFSET    = 32'h0,
  parameter logic [31:0] DIR_OFFSET     = 32'h4,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic        PARITY_ODD     = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [15:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [15:0] req1_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic        HREADY,
  input  logic        HREADYOUT,
  input  logic [31:0] HRDATA,
  input  logic        PARITYERR,
  output logic        PARITYSEL
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  xfer_t         xfer_q, xfer_d;
  op_e           op_q;
  logic [15:0]   wdata_q;
  logic          id_q;
  logic          dir_q;
  logic [CW-1:0] wait_cnt_q;

  logic [1:0]    gnt;
  logic          gnt_id;
  logic          accept;
  op_e           req_op;
  logic [15:0]   req_wdata;
  logic          addr_phase;
  logic          data_phase;
  logic          timeout;
  logic          unused_hrdata;

  assign unused_hrdata = ^HRDATA[31:16];

  // The transfer that carries the command itself.
  function automatic xfer_t data_xfer(input op_e op, input logic [15:0] wdata);
    xfer_t x;
    x.addr  = BASE_ADDR + DATA_OFFSET;
    x.write = (op == OP_WRITE_OUT);
    x.data  = (op == OP_WRITE_OUT) ? wdata : 16'h0000;
    if (op == OP_SET_DIR) begin
      x.addr  = BASE_ADDR + DIR_OFFSET;
      x.write = 1'b1;
      x.data  = {15'b0, wdata[0]};
    end
    return x;
  endfunction

  // Direction write inserted ahead of a data transfer whose intent disagrees with dir_q.
  function automatic xfer_t dir_xfer(input op_e op);
    xfer_t x;
    x.addr  = BASE_ADDR + DIR_OFFSET;
    x.write = 1'b1;
    x.data  = (op == OP_WRITE_OUT) ? DIR_OUT : DIR_IN;
    return x;
  endfunction

  function automatic logic needs_dir(input op_e op, input logic dir);
    return ((op == OP_WRITE_OUT) && !dir) || ((op == OP_READ_IN) && dir);
  endfunction

  rr_arb2 u_arb (
    .clk    (HCLK),
    .rst    (HRESET),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req0_ready = (state_q == ST_IDLE) & gnt[0];
  assign req1_ready = (state_q == ST_IDLE) & gnt[1];
  assign accept     = req0_ready | req1_ready;
  assign req_op     = op_e'(gnt_id ? req1_op : req0_op);
  assign req_wdata  = gnt_id ? req1_wdata : req0_wdata;

  assign addr_phase = (state_q == ST_DIR_A) || (state_q == ST_XFER_A);
  assign data_phase = (state_q == ST_DIR_D) || (state_q == ST_XFER_D);
  // A ready slave wins over an expiring counter on the same cycle.
  assign timeout    = data_phase && !HREADYOUT && (wait_cnt_q == CW'(TIMEOUT_CYCLES));

  // HADDR/HWDATA come from xfer_q so they stay stable through every wait state.
  assign HSEL      = addr_phase;
  assign HTRANS    = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE    = addr_phase & xfer_q.write;
  assign HADDR     = xfer_q.addr;
  assign HWDATA    = {16'h0000, xfer_q.data};
  assign HREADY    = HREADYOUT;
  assign PARITYSEL = PARITY_ODD;

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (req_op != OP_RSVD)) begin
          if (needs_dir(req_op, dir_q)) begin
            state_d = ST_DIR_A;
            xfer_d  = dir_xfer(req_op);
          end else begin
            state_d = ST_XFER_A;
            xfer_d  = data_xfer(req_op, req_wdata);
          end
        end
      end
      ST_DIR_A:  state_d = ST_DIR_D;
      ST_DIR_D: begin
        if (HREADYOUT) begin
          state_d = ST_XFER_A;
          xfer_d  = data_xfer(op_q, wdata_q);
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER_A: state_d = ST_XFER_D;
      ST_XFER_D: begin
        if (HREADYOUT || timeout) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      xfer_q     <= '0;
      op_q       <= OP_WRITE_OUT;
      wdata_q    <= 16'h0000;
      id_q       <= 1'b0;
      dir_q      <= 1'b0;
      wait_cnt_q <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_rdata  <= 16'h0000;
      rsp_err    <= 1'b0;
    end else begin
      xfer_q    <= xfer_d;
      rsp_valid <= 1'b0;

      if (data_phase && !HREADYOUT && !timeout) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end

      if (accept) begin
        op_q    <= req_op;
        wdata_q <= req_wdata;
        id_q    <= gnt_id;
        // Reserved op never touches the bus; answer with an error straight away.
        if (req_op == OP_RSVD) begin
          rsp_valid <= 1'b1;
          rsp_id    <= gnt_id;
          rsp_rdata <= 16'h0000;
          rsp_err   <= 1'b1;
        end
      end

      if ((state_q == ST_DIR_D) && HREADYOUT) begin
        dir_q <= (op_q == OP_WRITE_OUT);
      end

      if ((state_q == ST_XFER_D) && HREADYOUT) begin
        if (op_q == OP_SET_DIR) dir_q <= wdata_q[0];
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_rdata <= (op_q == OP_READ_IN) ? HRDATA[15:0] : 16'h0000;
        rsp_err   <= (op_q == OP_READ_IN) && PARITYERR;
      end

      if (timeout) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_rdata <= 16'h0000;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_gpio_ctrl.sv
// Directed bench for ahb_gpio_ctrl: command table plus arbitration and reset sequences.
// Latency: n/a.
// Backpressure: an AHB slave model inserts configurable wait states or hangs.
module tb_ahb_gpio_ctrl;

  localparam logic [31:0] B = 32'h5300_0000;

  logic        HCLK, HRESET;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_wdata, req1_wdata;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [15:0] rsp_rdata;
  logic        HSEL, HWRITE, HREADY, HREADYOUT, PARITYERR, PARITYSEL;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;

  ahb_gpio_ctrl dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .PARITYERR(PARITYERR),
    .PARITYSEL(PARITYSEL)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_now = 0;

  initial forever begin
    @(posedge HCLK);
    cyc_now++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slave model configuration and transfer log.
  int          cfg_wait  = 0;
  logic        cfg_stuck = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  logic        cfg_par   = 1'b0;
  int          nx = 0;
  int          stab_err = 0;
  logic [31:0] x_addr [4];
  logic        x_write[4];
  logic [31:0] x_wdata[4];
  logic        in_d = 1'b0;
  logic        first_d = 1'b0;
  int          dcnt = 0;
  logic [31:0] cur_addr, cur_wdata;

  // Decides HREADYOUT for the current cycle at the falling edge, before the DUT samples it.
  initial begin
    HREADYOUT = 1'b1;
    HRDATA    = 32'h0;
    PARITYERR = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        in_d = 1'b0; HREADYOUT = 1'b1; PARITYERR = 1'b0;
      end else begin
        if (in_d) begin
          if (first_d) begin
            if (nx > 0 && nx <= 4) x_wdata[nx-1] = HWDATA;
            cur_wdata = HWDATA;
            first_d = 1'b0;
          end else if (HADDR !== cur_addr || HWDATA !== cur_wdata) begin
            stab_err++;
          end
          if (cfg_stuck) begin
            HREADYOUT = 1'b0;
          end else if (dcnt > 0) begin
            HREADYOUT = 1'b0; dcnt--;
          end else begin
            HREADYOUT = 1'b1; HRDATA = cfg_rdata; PARITYERR = cfg_par;
          end
          if (HREADYOUT) in_d = 1'b0;
        end else begin
          HREADYOUT = 1'b1; PARITYERR = 1'b0;
        end
        if (HSEL && HTRANS == 2'b10) begin
          if (nx < 4) begin x_addr[nx] = HADDR; x_write[nx] = HWRITE; end
          nx++;
          in_d = 1'b1; first_d = 1'b1; dcnt = cfg_wait; cur_addr = HADDR;
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic        id;
    logic [1:0]  op;
    logic [15:0] wdata;
    logic [31:0] rdata;
    logic        par;
    int          waitc;
    logic        stuck;
    int          lat;
    int          nx;
    logic [31:0] a0, d0, al;
    logic        wl;
    logic [31:0] dl;
    logic [15:0] rexp;
    logic        eexp;
  } vec_t;

  vec_t vecs[10];
  int   t_rsp;

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge HCLK);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w, lat, li;
    nx = 0; stab_err = 0;
    cfg_wait = v.waitc; cfg_stuck = v.stuck; cfg_rdata = v.rdata; cfg_par = v.par;
    if (v.id) begin req1_valid = 1'b1; req1_op = v.op; req1_wdata = v.wdata; end
    else      begin req0_valid = 1'b1; req0_op = v.op; req0_wdata = v.wdata; end
    #1;
    w = 0;
    while (!(v.id ? req1_ready : req0_ready) && w < 40) begin
      @(negedge HCLK); #1; w++;
    end
    if (w >= 40) begin
      chk({v.name, ".accept"}, 32'(0), 32'(1));
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(negedge HCLK);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(lat);
    t_rsp = cyc_now;
    chk({v.name, ".lat"},   32'(lat),       32'(v.lat));
    chk({v.name, ".id"},    32'(rsp_id),    32'(v.id));
    chk({v.name, ".rdata"}, 32'(rsp_rdata), 32'(v.rexp));
    chk({v.name, ".err"},   32'(rsp_err),   32'(v.eexp));
    chk({v.name, ".bus_idle"}, 32'({HSEL, HTRANS}), 32'(0));
    chk({v.name, ".nxfer"}, 32'(nx), 32'(v.nx));
    chk({v.name, ".stable"}, 32'(stab_err), 32'(0));
    if (v.nx > 0 && nx > 0) begin
      li = (nx > 4) ? 3 : nx - 1;
      chk({v.name, ".addr0"},  x_addr[0],  v.a0);
      chk({v.name, ".wdata0"}, x_wdata[0], v.d0);
      chk({v.name, ".addrL"},  x_addr[li], v.al);
      chk({v.name, ".writeL"}, 32'(x_write[li]), 32'(v.wl));
      chk({v.name, ".wdataL"}, x_wdata[li], v.dl);
    end
    if (v.stuck) begin
      cfg_stuck = 1'b0;
      repeat (2) @(negedge HCLK);
    end
  endtask

  initial begin
    int lat, t_a, seen;
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t_a, seen;
    // name, id, op, wdata, rdata, par, wait, stuck, lat, nx, a0, d0, aL, wL, dL, rdata_exp, err_exp
    vecs[0] = '{"wr_dir_ins",   1'b0, 2'b00, 16'hA5A5, 32'h1111_2222, 1'b0, 0, 1'b0,  5, 2, B+4, 32'h1, B,   1'b1, 32'hA5A5, 16'h0,    1'b0};
    vecs[1] = '{"b2b_wr1",      1'b1, 2'b00, 16'h0001, 32'h0,         1'b0, 0, 1'b0,  3, 1, B,   32'h1, B,   1'b1, 32'h0001, 16'h0,    1'b0};
    vecs[2] = '{"b2b_wr2",      1'b1, 2'b00, 16'h0002, 32'h0,         1'b0, 0, 1'b0,  3, 1, B,   32'h2, B,   1'b1, 32'h0002, 16'h0,    1'b0};
    vecs[3] = '{"rd_wait_par",  1'b0, 2'b01, 16'h0000, 32'hDEAD_1234, 1'b1, 3, 1'b0,  6, 1, B,   32'h0, B,   1'b0, 32'h0,    16'h1234, 1'b1};
    vecs[4] = '{"set_dir",      1'b1, 2'b10, 16'hFFF1, 32'hBEEF_BEEF, 1'b0, 0, 1'b0,  3, 1, B+4, 32'h1, B+4, 1'b1, 32'h1,    16'h0,    1'b0};
    vecs[5] = '{"dir_timeout",  1'b0, 2'b01, 16'h0000, 32'h1234_5678, 1'b0, 0, 1'b1, 19, 1, B+4, 32'h0, B+4, 1'b1, 32'h0,    16'h0,    1'b1};
    vecs[6] = '{"rd_after_to",  1'b1, 2'b01, 16'h0000, 32'h5A5A_0F0F, 1'b0, 0, 1'b0,  5, 2, B+4, 32'h0, B,   1'b0, 32'h0,    16'h0F0F, 1'b0};
    vecs[7] = '{"reserved",     1'b0, 2'b11, 16'hFFFF, 32'h0,         1'b0, 0, 1'b0,  1, 0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 16'h0,    1'b1};
    vecs[8] = '{"data_timeout", 1'b1, 2'b01, 16'h0000, 32'hCAFE_CAFE, 1'b1, 0, 1'b1, 19, 1, B,   32'h0, B,   1'b0, 32'h0,    16'h0,    1'b1};
    vecs[9] = '{"wr_after_rst", 1'b0, 2'b00, 16'h00FF, 32'h0,         1'b0, 0, 1'b0,  5, 2, B+4, 32'h1, B,   1'b1, 32'h00FF, 16'h0,    1'b0};

    HRESET = 1'b1;
    req0_valid = 1'b0; req0_op = 2'b00; req0_wdata = 16'h0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_wdata = 16'h0;
    repeat (3) @(negedge HCLK);
    chk("rst.hsel",   32'(HSEL),      32'(0));
    chk("rst.htrans", 32'(HTRANS),    32'(0));
    chk("rst.hwrite", 32'(HWRITE),    32'(0));
    chk("rst.haddr",  HADDR,          32'h0);
    chk("rst.hwdata", HWDATA,         32'h0);
    chk("rst.rsp",    32'({rsp_valid, rsp_id, rsp_err, rsp_rdata}), 32'(0));
    chk("rst.parsel", 32'(PARITYSEL), 32'(1));
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("idle.ready", 32'({req1_ready, req0_ready}), 32'(0));

    run_vec(vecs[0]);
    run_vec(vecs[1]);
    t_a = t_rsp;
    run_vec(vecs[2]);
    chk("b2b.gap", 32'(t_rsp - t_a), 32'(3));

    // Simultaneous READ_IN from both sides: req0 wins, responses come back in grant order.
    nx = 0; cfg_wait = 0; cfg_stuck = 1'b0; cfg_par = 1'b0; cfg_rdata = 32'h9999_1111;
    req0_valid = 1'b1; req0_op = 2'b01; req0_wdata = 16'h0;
    req1_valid = 1'b1; req1_op = 2'b01; req1_wdata = 16'h0;
    #1;
    chk("both.grant", 32'({req1_ready, req0_ready}), 32'(1));
    @(negedge HCLK);
    req0_valid = 1'b0;
    wait_rsp(lat);
    chk("both.lat0",   32'(lat),       32'(5));
    chk("both.id0",    32'(rsp_id),    32'(0));
    chk("both.rdata0", 32'(rsp_rdata), 32'(16'h1111));
    chk("both.nx0",    32'(nx),        32'(2));
    chk("both.dir0",   x_wdata[0],     32'h0);
    #1;
    chk("both.ready1", 32'(req1_ready), 32'(1));
    cfg_rdata = 32'h7777_2222;
    nx = 0;
    @(negedge HCLK);
    req1_valid = 1'b0;
    wait_rsp(lat);
    chk("both.lat1",   32'(lat),       32'(3));
    chk("both.id1",    32'(rsp_id),    32'(1));
    chk("both.rdata1", 32'(rsp_rdata), 32'(16'h2222));
    chk("both.err1",   32'(rsp_err),   32'(0));
    chk("both.nx1",    32'(nx),        32'(1));

    for (int i = 3; i < 9; i++) run_vec(vecs[i]);

    // Reset while the slave stalls the data phase of a data write (after a direction insert).
    nx = 0; cfg_wait = 0; cfg_stuck = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_wdata = 16'h5555;
    #1;
    chk("rst_mid.accept", 32'(req0_ready), 32'(1));
    @(negedge HCLK);               // T1 DIR_A
    req0_valid = 1'b0;
    repeat (2) @(negedge HCLK);    // T3 XFER_A
    cfg_stuck = 1'b1;
    @(negedge HCLK);               // T4 XFER_D
    chk("rst_mid.in_data", HWDATA, 32'h5555);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("rst_mid.hsel",   32'({HSEL, HTRANS, HWRITE}), 32'(0));
    chk("rst_mid.haddr",  HADDR,  32'h0);
    chk("rst_mid.hwdata", HWDATA, 32'h0);
    chk("rst_mid.rsp",    32'({rsp_valid, rsp_id, rsp_err, rsp_rdata}), 32'(0));
    HRESET = 1'b0;
    cfg_stuck = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      if (rsp_valid) seen++;
    end
    chk("rst_mid.no_rsp", 32'(seen), 32'(0));

    run_vec(vecs[9]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
